// File: rtl/vscale_scoreboard.sv
// Register scoreboard and bypass selector for the DX issue point.
// Optional stall counters are enabled with `define VSCALE_SCOREBOARD_PERF_EN.
module vscale_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_WB_PORTS   = 2,
  parameter int SEL_WIDTH      = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]              issue_rs1,
  input  logic                                   issue_uses_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]              issue_rs2,
  input  logic                                   issue_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]              issue_rd,
  input  logic                                   issue_wr,
  input  logic [NUM_WB_PORTS-1:0]                wb_valid,
  input  logic [NUM_WB_PORTS*REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                                   cancel_valid,
  input  logic [REG_ADDR_WIDTH-1:0]              cancel_rd,
  output logic                                   stall_issue,
  output logic                                   bypass_rs1,
  output logic [SEL_WIDTH-1:0]                   bypass_rs1_sel,
  output logic                                   bypass_rs2,
  output logic [SEL_WIDTH-1:0]                   bypass_rs2_sel,
  output logic                                   spurious_wb
`ifdef VSCALE_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                            raw_stall_cnt,
  output logic [31:0]                            waw_stall_cnt
`endif
);

  // x0 has no entry: every lookup loop starts at 1, so x0 reads as never busy.
  logic [NUM_REGS-1:1] busy, busy_next;
  logic rs1_hit, rs2_hit, rd_hit;
  logic [SEL_WIDTH-1:0] rs1_sel, rs2_sel;
  logic rs1_busy, rs2_busy, rd_busy;
  logic raw1, raw2, waw, accept, spurious_next, clr;

  // Descending port scan so the lowest matching port ends up selected.
  always_comb begin
    rs1_hit  = 1'b0;
    rs2_hit  = 1'b0;
    rd_hit   = 1'b0;
    rs1_sel  = '0;
    rs2_sel  = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    rd_busy  = 1'b0;
    for (int i = NUM_WB_PORTS-1; i >= 0; i--) begin
      if (wb_valid[i] && wb_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == issue_rs1) begin
        rs1_hit = 1'b1;
        rs1_sel = SEL_WIDTH'(i);
      end
      if (wb_valid[i] && wb_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == issue_rs2) begin
        rs2_hit = 1'b1;
        rs2_sel = SEL_WIDTH'(i);
      end
      if (wb_valid[i] && wb_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == issue_rd)
        rd_hit = 1'b1;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_rs1 == REG_ADDR_WIDTH'(r)) rs1_busy = busy[r];
      if (issue_rs2 == REG_ADDR_WIDTH'(r)) rs2_busy = busy[r];
      if (issue_rd  == REG_ADDR_WIDTH'(r)) rd_busy  = busy[r];
    end
  end

  assign raw1           = issue_uses_rs1 && rs1_busy && !rs1_hit;
  assign raw2           = issue_uses_rs2 && rs2_busy && !rs2_hit;
  assign waw            = issue_wr && rd_busy && !rd_hit;
  assign bypass_rs1     = issue_uses_rs1 && rs1_busy && rs1_hit;
  assign bypass_rs2     = issue_uses_rs2 && rs2_busy && rs2_hit;
  assign bypass_rs1_sel = bypass_rs1 ? rs1_sel : '0;
  assign bypass_rs2_sel = bypass_rs2 ? rs2_sel : '0;
  assign stall_issue    = issue_valid && (raw1 || raw2 || waw);
  assign accept         = issue_valid && !stall_issue;

  // A newly accepted write outranks any same-cycle writeback or cancel on that register.
  always_comb begin
    busy_next     = busy;
    spurious_next = 1'b0;
    clr           = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      clr = cancel_valid && (cancel_rd == REG_ADDR_WIDTH'(r));
      for (int i = 0; i < NUM_WB_PORTS; i++)
        if (wb_valid[i] && wb_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(r))
          clr = 1'b1;
      if (clr && !busy[r])
        spurious_next = 1'b1;
      if (accept && issue_wr && issue_rd == REG_ADDR_WIDTH'(r))
        busy_next[r] = 1'b1;
      else if (clr)
        busy_next[r] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      spurious_wb <= 1'b0;
    end else begin
      busy        <= busy_next;
      spurious_wb <= spurious_next;
    end
  end

`ifdef VSCALE_SCOREBOARD_PERF_EN
  // RAW takes precedence: a cycle stalled by both counts only as RAW.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_stall_cnt <= '0;
      waw_stall_cnt <= '0;
    end else if (issue_valid && (raw1 || raw2)) begin
      raw_stall_cnt <= raw_stall_cnt + 32'd1;
    end else if (issue_valid && waw) begin
      waw_stall_cnt <= waw_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_scoreboard.sv
// Self-checking bench for vscale_scoreboard: directed scenarios plus random traffic
// checked against a behavioural scoreboard model.
module tb_vscale_scoreboard;

  localparam int NR  = 32;
  localparam int RAW = 5;
  localparam int NP  = 2;
  localparam int SW  = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, issue_uses_rs1, issue_uses_rs2, issue_wr;
  logic [RAW-1:0]  issue_rs1, issue_rs2, issue_rd, cancel_rd;
  logic [NP-1:0]   wb_valid;
  logic [NP*RAW-1:0] wb_rd;
  logic            cancel_valid;
  logic            stall_issue, bypass_rs1, bypass_rs2, spurious_wb;
  logic [SW-1:0]   bypass_rs1_sel, bypass_rs2_sel;
`ifdef VSCALE_SCOREBOARD_PERF_EN
  logic [31:0]     raw_stall_cnt, waw_stall_cnt;
`endif

  vscale_scoreboard #(.NUM_REGS(NR), .REG_ADDR_WIDTH(RAW), .NUM_WB_PORTS(NP), .SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_uses_rs1(issue_uses_rs1),
    .issue_rs2(issue_rs2), .issue_uses_rs2(issue_uses_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .cancel_valid(cancel_valid), .cancel_rd(cancel_rd),
    .stall_issue(stall_issue),
    .bypass_rs1(bypass_rs1), .bypass_rs1_sel(bypass_rs1_sel),
    .bypass_rs2(bypass_rs2), .bypass_rs2_sel(bypass_rs2_sel),
    .spurious_wb(spurious_wb)
`ifdef VSCALE_SCOREBOARD_PERF_EN
    , .raw_stall_cnt(raw_stall_cnt), .waw_stall_cnt(waw_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          stall;
    logic          b1;
    logic [SW-1:0] s1;
    logic          b2;
    logic [SW-1:0] s2;
    logic          spur;
  } exp_t;

  exp_t expq[$];
  logic busy_m [NR];
  logic spur_m;
  int   raw_m, waw_m;
  int   total = 0;
  int   bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drives one cycle of inputs, predicts and checks outputs, then advances the model.
  task automatic applyStimulus(input string tag, input logic iv,
                               input logic [RAW-1:0] rs1, input logic u1,
                               input logic [RAW-1:0] rs2, input logic u2,
                               input logic [RAW-1:0] rd, input logic wr,
                               input logic [NP-1:0] wbv, input logic [RAW-1:0] w0, input logic [RAW-1:0] w1,
                               input logic cv, input logic [RAW-1:0] crd);
    exp_t e;
    logic h1, h2, hd, r1, r2, ww, acc, nspur, clrr;
    logic [SW-1:0] s1, s2;
    @(negedge clk);
    issue_valid = iv; issue_rs1 = rs1; issue_uses_rs1 = u1;
    issue_rs2 = rs2; issue_uses_rs2 = u2; issue_rd = rd; issue_wr = wr;
    wb_valid = wbv; wb_rd = {w1, w0}; cancel_valid = cv; cancel_rd = crd;
    h1 = 1'b0; s1 = '0; h2 = 1'b0; s2 = '0;
    if (wbv[0] && w0 == rs1) h1 = 1'b1;
    else if (wbv[1] && w1 == rs1) begin h1 = 1'b1; s1 = 1'b1; end
    if (wbv[0] && w0 == rs2) h2 = 1'b1;
    else if (wbv[1] && w1 == rs2) begin h2 = 1'b1; s2 = 1'b1; end
    hd = (wbv[0] && w0 == rd) || (wbv[1] && w1 == rd);
    r1 = u1 && rs1 != 0 && busy_m[rs1] && !h1;
    r2 = u2 && rs2 != 0 && busy_m[rs2] && !h2;
    ww = wr && rd != 0 && busy_m[rd] && !hd;
    e.tag   = tag;
    e.stall = iv && (r1 || r2 || ww);
    e.b1    = u1 && rs1 != 0 && busy_m[rs1] && h1;
    e.s1    = e.b1 ? s1 : '0;
    e.b2    = u2 && rs2 != 0 && busy_m[rs2] && h2;
    e.s2    = e.b2 ? s2 : '0;
    e.spur  = spur_m;
    expq.push_back(e);
    #1;
    e = expq.pop_front();
    checkOutput({e.tag, ".stall"}, 32'(stall_issue), 32'(e.stall));
    checkOutput({e.tag, ".byp1"}, 32'(bypass_rs1), 32'(e.b1));
    checkOutput({e.tag, ".sel1"}, 32'(bypass_rs1_sel), 32'(e.s1));
    checkOutput({e.tag, ".byp2"}, 32'(bypass_rs2), 32'(e.b2));
    checkOutput({e.tag, ".sel2"}, 32'(bypass_rs2_sel), 32'(e.s2));
    checkOutput({e.tag, ".spur"}, 32'(spurious_wb), 32'(e.spur));
    acc   = iv && !e.stall;
    nspur = (wbv[0] && w0 != 0 && !busy_m[w0]) || (wbv[1] && w1 != 0 && !busy_m[w1]) ||
            (cv && crd != 0 && !busy_m[crd]);
    for (int r = 1; r < NR; r++) begin
      clrr = (wbv[0] && w0 == RAW'(r)) || (wbv[1] && w1 == RAW'(r)) || (cv && crd == RAW'(r));
      if (acc && wr && rd == RAW'(r)) busy_m[r] = 1'b1;
      else if (clrr) busy_m[r] = 1'b0;
    end
    spur_m = nspur;
    if (iv && (r1 || r2)) raw_m++;
    else if (iv && ww) waw_m++;
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_wr = 0;
    wb_valid = '0; cancel_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < NR; r++) busy_m[r] = 1'b0;
    spur_m = 1'b0;
    raw_m = 0;
    waw_m = 0;
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_rs1 = 0; issue_uses_rs1 = 0; issue_rs2 = 0; issue_uses_rs2 = 0;
    issue_rd = 0; issue_wr = 0; wb_valid = '0; wb_rd = '0; cancel_valid = 0; cancel_rd = 0;
    doReset();
    idle("rst");

    // RAW stall then bypass from port 1
    applyStimulus("t1a", 1, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0);
    applyStimulus("t1b", 1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    checkOutput("t1b.stall_k", 32'(stall_issue), 32'd1);
    applyStimulus("t1c", 1, 5, 1, 0, 0, 0, 0, 2'b10, 0, 5, 0, 0);
    checkOutput("t1c.stall_k", 32'(stall_issue), 32'd0);
    checkOutput("t1c.byp1_k", 32'(bypass_rs1), 32'd1);
    checkOutput("t1c.sel1_k", 32'(bypass_rs1_sel), 32'd1);

    // WAW stall resolved by cancel
    applyStimulus("t2a", 1, 0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0);
    applyStimulus("t2b", 1, 0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0);
    checkOutput("t2b.stall_k", 32'(stall_issue), 32'd1);
    applyStimulus("t2c", 1, 0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 1, 3);
    applyStimulus("t2d", 1, 0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0);
    checkOutput("t2d.stall_k", 32'(stall_issue), 32'd0);
    applyStimulus("t2e", 1, 3, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    checkOutput("t2e.stall_k", 32'(stall_issue), 32'd1);
    applyStimulus("t2f", 0, 0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0, 0);

    // accept beats same-cycle writeback on the same register
    applyStimulus("t3a", 1, 0, 0, 0, 0, 7, 1, 2'b01, 7, 0, 0, 0);
    applyStimulus("t3b", 1, 0, 0, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    checkOutput("t3b.stall_k", 32'(stall_issue), 32'd1);
    applyStimulus("t3c", 0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0);

    // x0 is never tracked
    applyStimulus("t4a", 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    applyStimulus("t4b", 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    checkOutput("t4b.stall_k", 32'(stall_issue), 32'd0);
    checkOutput("t4b.byp1_k", 32'(bypass_rs1), 32'd0);
    applyStimulus("t4c", 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0);
    idle("t4d");
    checkOutput("t4d.spur_k", 32'(spurious_wb), 32'd0);

    // spurious writeback pulse
    applyStimulus("t5a", 0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0);
    idle("t5b");
    checkOutput("t5b.spur_k", 32'(spurious_wb), 32'd1);
    idle("t5c");
    checkOutput("t5c.spur_k", 32'(spurious_wb), 32'd0);

    // reset drops pending entries
    applyStimulus("t6a", 1, 0, 0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 0);
    doReset();
    applyStimulus("t6b", 1, 4, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    checkOutput("t6b.stall_k", 32'(stall_issue), 32'd0);
    applyStimulus("t6c", 0, 0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 0, 0);
    idle("t6d");
    checkOutput("t6d.spur_k", 32'(spurious_wb), 32'd1);

    // three RAW stall cycles then two WAW-only stall cycles
    doReset();
    applyStimulus("p0", 1, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus("praw", 1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) applyStimulus("pwaw", 1, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 0);
    idle("p1");
`ifdef VSCALE_SCOREBOARD_PERF_EN
    checkOutput("perf.raw", raw_stall_cnt, 32'd3);
    checkOutput("perf.waw", waw_stall_cnt, 32'd2);
    doReset();
    checkOutput("perf.raw_rst", raw_stall_cnt, 32'd0);
    checkOutput("perf.waw_rst", waw_stall_cnt, 32'd0);
`else
    doReset();
`endif

    // random traffic over a small register window to provoke hits
    for (int n = 0; n < 600; n++) begin
      applyStimulus("rnd", 1'($urandom_range(0, 3) != 0),
                    RAW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    RAW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    RAW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    NP'($urandom_range(0, 3)), RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 7) == 0), RAW'($urandom_range(0, 7)));
    end
`ifdef VSCALE_SCOREBOARD_PERF_EN
    checkOutput("rnd.raw_cnt", raw_stall_cnt, 32'(raw_m));
    checkOutput("rnd.waw_cnt", waw_stall_cnt, 32'(waw_m));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
